// File: rtl/rca_lsu_arbiter_if.sv
// Bundle of CPU, RCA and LSU request/response signals shared by the LSU arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface rca_lsu_arbiter_if #(
    parameter int XLEN = 32
);
    logic            cpu_new_request;
    logic [XLEN-1:0] cpu_addr;
    logic [XLEN-1:0] cpu_data;
    logic [2:0]      cpu_fn3;
    logic            cpu_load;
    logic            cpu_store;
    logic            cpu_ready;

    logic            rca_new_request;
    logic [XLEN-1:0] rca_addr;
    logic [XLEN-1:0] rca_data;
    logic [2:0]      rca_fn3;
    logic            rca_load;
    logic            rca_store;
    logic            rca_ready;
    logic            rca_lsu_lock;

    logic            lsu_new_request;
    logic [XLEN-1:0] lsu_addr;
    logic [XLEN-1:0] lsu_data;
    logic [2:0]      lsu_fn3;
    logic            lsu_load;
    logic            lsu_store;
    logic            lsu_ready;
    logic            lsu_load_complete;
    logic [XLEN-1:0] lsu_load_data;

    logic            cpu_load_complete;
    logic            rca_load_complete;
    logic [XLEN-1:0] load_data;
    logic            rca_owns;
    logic            underflow_err;

    modport slave (
        input  cpu_new_request, cpu_addr, cpu_data, cpu_fn3, cpu_load, cpu_store,
        output cpu_ready,
        input  rca_new_request, rca_addr, rca_data, rca_fn3, rca_load, rca_store,
        output rca_ready,
        input  rca_lsu_lock,
        output lsu_new_request, lsu_addr, lsu_data, lsu_fn3, lsu_load, lsu_store,
        input  lsu_ready, lsu_load_complete, lsu_load_data,
        output cpu_load_complete, rca_load_complete, load_data, rca_owns, underflow_err
    );

    modport master (
        output cpu_new_request, cpu_addr, cpu_data, cpu_fn3, cpu_load, cpu_store,
        input  cpu_ready,
        output rca_new_request, rca_addr, rca_data, rca_fn3, rca_load, rca_store,
        input  rca_ready,
        output rca_lsu_lock,
        input  lsu_new_request, lsu_addr, lsu_data, lsu_fn3, lsu_load, lsu_store,
        output lsu_ready, lsu_load_complete, lsu_load_data,
        input  cpu_load_complete, rca_load_complete, load_data, rca_owns, underflow_err
    );
endinterface

// File: rtl/rca_lsu_arbiter.sv
// Arbitrates a single LSU between the CPU and the RCA load/store queue, draining loads on handover.
// Optional macro RCA_LSU_ARB_PERF_EN adds the drain_cycles performance counter output.
module rca_lsu_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN            = 32
) (
    input  logic                clk,
    input  logic                rst,
    rca_lsu_arbiter_if.slave    bus
`ifdef RCA_LSU_ARB_PERF_EN
    ,
    output logic [31:0]         drain_cycles
`endif
);
    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_CPU,
        S_DRAIN_TO_RCA,
        S_RCA,
        S_DRAIN_TO_CPU
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            underflow_q, underflow_d;

    logic            full;
    logic            cpu_grant;
    logic            rca_grant;
    logic            issue_load;
    logic            cpu_side;
    logic [XLEN-1:0] mux_addr;
    logic [XLEN-1:0] mux_data;
    logic [2:0]      mux_fn3;
    logic            mux_load;
    logic            mux_store;

    // Grants are combinational so a request is accepted in the same cycle it is presented.
    always_comb begin
        full      = (count_q == CNT_MAX);
        cpu_grant = (state_q == S_CPU) && !rst && bus.lsu_ready && !full;
        rca_grant = (state_q == S_RCA) && !rst && bus.lsu_ready && !full;
        cpu_side  = (state_q == S_CPU) || (state_q == S_DRAIN_TO_RCA);

        if (state_q == S_RCA) begin
            mux_addr  = bus.rca_addr;
            mux_data  = bus.rca_data;
            mux_fn3   = bus.rca_fn3;
            mux_load  = bus.rca_load;
            mux_store = bus.rca_store;
        end else begin
            mux_addr  = bus.cpu_addr;
            mux_data  = bus.cpu_data;
            mux_fn3   = bus.cpu_fn3;
            mux_load  = bus.cpu_load;
            mux_store = bus.cpu_store;
        end
    end

    assign bus.cpu_ready         = cpu_grant;
    assign bus.rca_ready         = rca_grant;
    assign bus.lsu_new_request   = (cpu_grant && bus.cpu_new_request) ||
                                   (rca_grant && bus.rca_new_request);
    assign bus.lsu_addr          = mux_addr;
    assign bus.lsu_data          = mux_data;
    assign bus.lsu_fn3           = mux_fn3;
    assign bus.lsu_load          = mux_load;
    assign bus.lsu_store         = mux_store;
    assign bus.load_data         = bus.lsu_load_data;
    assign bus.cpu_load_complete = bus.lsu_load_complete && cpu_side && !rst;
    assign bus.rca_load_complete = bus.lsu_load_complete && !cpu_side && !rst;
    assign bus.rca_owns          = (state_q == S_RCA);
    assign bus.underflow_err     = underflow_q;

    assign issue_load = bus.lsu_new_request && mux_load && !mux_store;

    // Ownership only changes hands once every load issued by the previous owner has returned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CPU: begin
                if (bus.rca_lsu_lock) state_d = S_DRAIN_TO_RCA;
            end
            S_DRAIN_TO_RCA: begin
                if (!bus.rca_lsu_lock)  state_d = S_CPU;
                else if (count_q == '0) state_d = S_RCA;
            end
            S_RCA: begin
                if (!bus.rca_lsu_lock) state_d = S_DRAIN_TO_CPU;
            end
            S_DRAIN_TO_CPU: begin
                if (bus.rca_lsu_lock)   state_d = S_RCA;
                else if (count_q == '0) state_d = S_CPU;
            end
            default: state_d = S_CPU;
        endcase
    end

    // A completion with nothing outstanding cannot be matched to a load, so it is flagged instead.
    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        if (issue_load && !bus.lsu_load_complete) begin
            count_d = count_q + 1'b1;
        end else if (!issue_load && bus.lsu_load_complete) begin
            if (count_q == '0) underflow_d = 1'b1;
            else               count_d     = count_q - 1'b1;
        end
    end

`ifdef RCA_LSU_ARB_PERF_EN
    logic [31:0] drain_cycles_q, drain_cycles_d;

    always_comb begin
        drain_cycles_d = drain_cycles_q;
        if (((state_q == S_DRAIN_TO_RCA) || (state_q == S_DRAIN_TO_CPU)) &&
            (drain_cycles_q != '1))
            drain_cycles_d = drain_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drain_cycles_q <= '0;
        else     drain_cycles_q <= drain_cycles_d;
    end

    assign drain_cycles = drain_cycles_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CPU;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_rca_lsu_arbiter.sv
// Directed bench for rca_lsu_arbiter: handover draining, full blocking, underflow and reset.
// Build with RCA_LSU_ARB_PERF_EN defined to also cover the drain_cycles counter.
module tb_rca_lsu_arbiter;
    logic clk;
    logic rst;
    int   assert_count = 0;
    int   fail_count   = 0;

    rca_lsu_arbiter_if #(.XLEN(32)) bus ();

`ifdef RCA_LSU_ARB_PERF_EN
    logic [31:0] drain_cycles;
`endif

    rca_lsu_arbiter #(
        .MAX_OUTSTANDING(4),
        .XLEN(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RCA_LSU_ARB_PERF_EN
        ,
        .drain_cycles (drain_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the falling edge so checks never race the rising edge.
    task automatic applyStimulus(input logic cpu_req, input logic rca_req, input logic lock,
                                 input logic ready, input logic complete);
        bus.cpu_new_request   = cpu_req;
        bus.rca_new_request   = rca_req;
        bus.rca_lsu_lock      = lock;
        bus.lsu_ready         = ready;
        bus.lsu_load_complete = complete;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst                   = 1'b0;
        bus.cpu_new_request   = 1'b0;
        bus.cpu_addr          = 32'h100;
        bus.cpu_data          = 32'h0;
        bus.cpu_fn3           = 3'b010;
        bus.cpu_load          = 1'b1;
        bus.cpu_store         = 1'b0;
        bus.rca_new_request   = 1'b0;
        bus.rca_addr          = 32'h200;
        bus.rca_data          = 32'h0;
        bus.rca_fn3           = 3'b010;
        bus.rca_load          = 1'b1;
        bus.rca_store         = 1'b0;
        bus.rca_lsu_lock      = 1'b0;
        bus.lsu_ready         = 1'b0;
        bus.lsu_load_complete = 1'b0;
        bus.lsu_load_data     = 32'h0;
        #1 rst = 1'b1;

        // Everything quiet while reset is held, even with live requests
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("rst_cpu_ready",     bus.cpu_ready,         0);
        checkOutput("rst_lsu_new_req",   bus.lsu_new_request,   0);
        checkOutput("rst_cpu_complete",  bus.cpu_load_complete, 0);
        checkOutput("rst_rca_owns",      bus.rca_owns,          0);
        checkOutput("rst_underflow",     bus.underflow_err,     0);
        checkOutput("rst_count",         dut.count_q,           0);
        @(negedge clk);
        rst = 1'b0;

        // First CPU load goes straight through
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("cpu_lsu_new_req",   bus.lsu_new_request,   1);
        checkOutput("cpu_lsu_addr",      bus.lsu_addr,          32'h100);
        checkOutput("cpu_ready",         bus.cpu_ready,         1);
        checkOutput("cpu_rca_ready",     bus.rca_ready,         0);
        tick();
        checkOutput("cpu_count1",        dut.count_q,           1);

        // Second load issues in the very cycle the lock rises
        bus.cpu_addr = 32'h104;
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("lock_rise_issue",   bus.lsu_new_request,   1);
        checkOutput("lock_rise_addr",    bus.lsu_addr,          32'h104);
        tick();
        checkOutput("drain_rca_owns",    bus.rca_owns,          0);
        checkOutput("drain_count2",      dut.count_q,           2);
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("drain_cpu_ready",   bus.cpu_ready,         0);
        checkOutput("drain_rca_ready",   bus.rca_ready,         0);
        checkOutput("drain_lsu_new_req", bus.lsu_new_request,   0);

        bus.lsu_load_data = 32'hAAAA_0001;
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("drain_cpu_cmpl1",   bus.cpu_load_complete, 1);
        checkOutput("drain_rca_cmpl1",   bus.rca_load_complete, 0);
        checkOutput("drain_load_data",   bus.load_data,         32'hAAAA_0001);
        tick();
        checkOutput("drain_count1",      dut.count_q,           1);
        bus.lsu_load_data = 32'hAAAA_0002;
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("drain_cpu_cmpl2",   bus.cpu_load_complete, 1);
        tick();
        checkOutput("drain_count0",      dut.count_q,           0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("drain_zero_wait",   bus.rca_ready,         0);
        checkOutput("drain_zero_owns",   bus.rca_owns,          0);
        tick();
        checkOutput("rca_owns",          bus.rca_owns,          1);
        checkOutput("rca_ready",         bus.rca_ready,         1);
        checkOutput("rca_lsu_new_req",   bus.lsu_new_request,   1);
        checkOutput("rca_lsu_addr",      bus.lsu_addr,          32'h200);
`ifdef RCA_LSU_ARB_PERF_EN
        checkOutput("perf_drain3",       drain_cycles,          3);
`endif

        // Fill up with RCA loads; a simultaneous issue and completion leaves the count alone
        tick();
        checkOutput("rca_count1",        dut.count_q,           1);
        tick();
        tick();
        checkOutput("rca_count3",        dut.count_q,           3);
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("rca_issue_cmpl",    bus.lsu_new_request,   1);
        checkOutput("rca_cmpl_route",    bus.rca_load_complete, 1);
        checkOutput("rca_cmpl_cpu",      bus.cpu_load_complete, 0);
        tick();
        checkOutput("rca_same_cycle",    dut.count_q,           3);
        applyStimulus(0, 1, 1, 1, 0);
        tick();
        checkOutput("rca_count4",        dut.count_q,           4);
        checkOutput("full_rca_ready",    bus.rca_ready,         0);
        checkOutput("full_lsu_new_req",  bus.lsu_new_request,   0);
        bus.rca_load  = 1'b0;
        bus.rca_store = 1'b1;
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("full_blocks_store", bus.rca_ready,         0);
        bus.rca_load  = 1'b1;
        bus.rca_store = 1'b0;

        // Hand back toward the CPU with one load still out, then change our mind
        applyStimulus(0, 0, 1, 1, 1);
        tick();
        tick();
        tick();
        checkOutput("rca_count_back1",   dut.count_q,           1);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        checkOutput("d2c_rca_owns",      bus.rca_owns,          0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("d2c_cpu_ready",     bus.cpu_ready,         0);
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("d2c_relock_cpu",    bus.cpu_ready,         0);
        tick();
        checkOutput("relock_rca_owns",   bus.rca_owns,          1);
        checkOutput("relock_cpu_ready",  bus.cpu_ready,         0);
        checkOutput("relock_count",      dut.count_q,           1);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("relock_rca_cmpl",   bus.rca_load_complete, 1);
        tick();
        checkOutput("relock_count0",     dut.count_q,           0);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        tick();
        checkOutput("back_cpu_owns",     bus.rca_owns,          0);
        checkOutput("back_cpu_ready",    bus.cpu_ready,         1);

        // Stray completion with nothing outstanding
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("uf_cpu_cmpl",       bus.cpu_load_complete, 1);
        tick();
        checkOutput("uf_set",            bus.underflow_err,     1);
        checkOutput("uf_count0",         dut.count_q,           0);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        tick();
        checkOutput("uf_sticky",         bus.underflow_err,     1);
        rst = 1'b1;
        #1;
        checkOutput("uf_cleared",        bus.underflow_err,     0);
        tick();
        rst = 1'b0;

        // Reset during a drain forgets the outstanding load
        applyStimulus(1, 0, 0, 1, 0);
        tick();
        checkOutput("md_count1",         dut.count_q,           1);
        applyStimulus(0, 0, 1, 1, 0);
        tick();
        checkOutput("md_in_drain",       bus.rca_owns,          0);
        rst = 1'b1;
        #1;
        checkOutput("md_rst_count",      dut.count_q,           0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 1);
        tick();
        checkOutput("md_late_underflow", bus.underflow_err,     1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
